// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer scheduler and its arbiter.
package timer_sched_pkg;

    // Default width of the shared down-counter.
    localparam int DEFAULT_CNT_W = 26;

    // Requester indices never exceed 7, so three bits always suffice.
    localparam int IDX_W = 3;

    // Scheduler FSM encoding; also exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Advance a requester index by one, wrapping after the last requester.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] last);
        if (idx == last) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] dbl_gnt;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_gnt = rot_req & (~rot_req + N'(1));
        dbl_gnt = {{N{1'b0}}, rot_gnt} << ptr;
        gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one down-counter among N_REQ requesters, granted round-robin.
//
// Handshake: a requester raises req[i] (level) and holds it; the scheduler
// answers with grant[i] while it owns the counter and a single-cycle done[i]
// when its delay has expired. Dropping req[i] while granted aborts the timing
// with no done. delay is sampled only on the grant edge.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] delay,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count_out,
    output logic [1:0]             state_dbg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic [N_REQ-1:0]   winner;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   win_delay;
    logic               owner_req;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (winner)
    );

    // Translate the one-hot winner into its index and its delay lane.
    always_comb begin
        win_idx   = '0;
        win_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                win_idx   = IDX_W'(i);
                win_delay = delay[i*CNT_W +: CNT_W];
            end
        end
    end

    // The owner still wants the counter when its req bit is up.
    assign owner_req = |(req & grant_q);

    // Next-state, counter, grant, done and pointer updates.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    count_d = win_delay;
                    grant_d = winner;
                    owner_d = win_idx;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Abort wins over expiry when both happen on the same edge.
                if (!owner_req) begin
                    grant_d = '0;
                    ptr_d   = wrap_inc(owner_q, LAST_IDX);
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = wrap_inc(owner_q, LAST_IDX);
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any timing in flight without a done.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign count_out = count_q;
    assign state_dbg = state_q;

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one down-counter timing resource among `N_REQ` requesters. Each requester asks for a delay of up to 2^CNT_W−1 cycles. The block grants the counter round-robin, loads the requester's delay, counts it down, and returns a one-cycle `done` pulse to the owner. It sits between the control logic of the filter processor and the counter datapath, replacing per-unit free-running counters.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 26: counter width in bits.

- `clock`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: per-requester level request; held until `done` or dropped to abort.
- `delay`  in  N_REQ*CNT_W: flattened delays; requester i uses bits [i*CNT_W +: CNT_W]; sampled only at grant.
- `grant`  out  N_REQ: one-hot current owner; zero when idle.
- `done`  out  N_REQ: one-cycle pulse to the owner when its delay expires.
- `busy`  out  1: high in COUNT and DONE.
- `count_out`  out  CNT_W: remaining count of the active timing.

## Operation
- Reset values: state IDLE; `grant`=0, `done`=0, `busy`=0, `count_out`=0; round-robin pointer `ptr`=0.
- States:
  - IDLE: if any `req` bit is set, choose the winner: the first set bit at or after `ptr`, wrapping modulo N_REQ. Latch its delay into the count, set its `grant` bit, go to COUNT. Otherwise stay in IDLE.
  - COUNT:
    - If `req[owner]`=0, abort: clear `grant`, set `ptr`=owner+1 (mod N_REQ), go to IDLE, no `done`.
    - Else if count==0, go to DONE.
    - Else decrement count by 1.
  - DONE: `done[owner]`=1 for this cycle only. Clear `grant`, set `ptr`=owner+1 (mod N_REQ), go to IDLE.
- Abort has priority over expiry when `req` drops in the same cycle that count==0.
- Delay arithmetic is unsigned. No wrap below zero; count stops at 0.
- `delay` changes after grant have no effect on the active timing.
- A requester that keeps `req` high after `done` is eligible again. Because `ptr` has moved past it, other pending requesters are served first.
- `req` bits of non-owners are ignored outside IDLE.
- Asserting `rst` mid-operation returns immediately to reset values. No `done` is issued for the interrupted timing.

## Timing
- Request sampled in IDLE at edge k → `grant` high from edge k.
- With delay D, `done` is high in the cycle following edge k+D+1. Latency from the grant edge to the `done` cycle is D+2 cycles; D=0 gives 2.
- `busy` is high from edge k until edge k+D+2. Back-to-back grants therefore have a one-cycle IDLE gap.
- `count_out` equals D in the first COUNT cycle and then decrements by 1 each cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `timer_sched_pkg`: state encoding (IDLE, COUNT, DONE) as localparams or typedef, plus default `CNT_W`.
- Sub-module `rr_arbiter` (parameter `N`): inputs are the request vector and `ptr`; output is the one-hot winner; purely combinational.
- The FSM, counter and pointer register live in the top module.

## Test plan
- Reset: assert `rst` mid-COUNT → all outputs 0 asynchronously; after release, `req`=0001 with D=3 → `done[0]` pulses 5 cycles after the grant edge.
- D=0 on requester 2 → `grant`=0100 for 2 cycles, then `done`=0100 for exactly one cycle.
- Round-robin: hold `req`=1111 with all D=1 → grant order 0,1,2,3,0; each `done` pulse 3 cycles apart plus a one-cycle IDLE gap.
- Abort: requester 1, D=10, drop `req[1]` after 4 COUNT cycles → no `done`; next grant goes to the lowest set `req` bit at or after index 2.
- Simultaneous drop and expiry: drop `req` in the cycle count==0 → no `done`; `busy` falls on the next edge.
- Full width: D=2^26−1 on requester 3 with forced `count_out` sampling → count decrements monotonically, `done` after D+2 cycles, no wrap-around.
